// File: rtl/uart_tx_core_pkg.sv
// Shared definitions for the UART transmitter: FSM encoding, parity
// selection values and the prescale floor.
package uart_tx_core_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam logic       PARITY_EVEN  = 1'b0;
    localparam logic       PARITY_ODD   = 1'b1;
    localparam logic [5:0] MIN_PRESCALE = 6'd4;

    // Prescale values below the floor are clamped so a bit never shrinks under 4 cycles.
    function automatic logic [5:0] eff_prescale(input logic [5:0] ps);
        return (ps < MIN_PRESCALE) ? MIN_PRESCALE : ps;
    endfunction

endpackage

// File: rtl/uart_tx_core_edge_bit_counter.sv
// Edge/bit counter: counts clock edges within a bit and data-bit index,
// same contract as the receiver-side counter.
module tx_edge_bit_counter #(
    parameter int data_width = 8,
    parameter int bits       = 3
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            en_i,
    input  logic            clr_i,
    input  logic            bit_en_i,
    input  logic [5:0]      ps_i,
    output logic [bits-1:0] bit_idx_o,
    output logic            wrap_o
);

    localparam logic [bits-1:0] LAST_BIT = bits'(data_width - 1);

    logic [5:0]      edge_q;
    logic [bits-1:0] bit_q;

    assign wrap_o    = en_i & (edge_q == (ps_i - 6'd1));
    assign bit_idx_o = bit_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            edge_q <= '0;
            bit_q  <= '0;
        end else if (clr_i) begin
            edge_q <= '0;
            bit_q  <= '0;
        end else if (en_i) begin
            edge_q <= wrap_o ? 6'd0 : edge_q + 6'd1;
            if (wrap_o && bit_en_i) begin
                bit_q <= (bit_q == LAST_BIT) ? '0 : bit_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: start bit, LSB-first payload, optional parity, one stop bit,
// each bit held for the prescale captured when the frame was accepted.
module uart_tx_core
    import uart_tx_core_pkg::*;
#(
    parameter int data_width = 8,
    parameter int bits       = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [data_width-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  Parity_Enable,
    input  logic                  Parity_Type,
    input  logic [5:0]            Prescale,
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam logic [bits-1:0] LAST_BIT = bits'(data_width - 1);

    tx_state_e             state_q;
    logic [data_width-1:0] data_q;
    logic                  par_en_q;
    logic                  par_bit_q;
    logic [5:0]            ps_q;
    logic                  tx_q;
    logic                  busy_q;

    logic            wrap;
    logic [bits-1:0] bit_idx;
    logic [bits-1:0] next_idx;
    logic            stop_last;
    logic            accept;
    logic            par_bit_d;

    assign stop_last = (state_q == ST_STOP) & wrap;
    // A new frame may be taken on the final stop cycle, giving gap-free back-to-back frames.
    assign accept    = Data_Valid & (~busy_q | stop_last);
    assign next_idx  = bit_idx + 1'b1;
    assign par_bit_d = (Parity_Type == PARITY_EVEN) ? (^P_DATA) : ~(^P_DATA);

    tx_edge_bit_counter #(
        .data_width (data_width),
        .bits       (bits)
    ) u_cnt (
        .clk_i     (CLK),
        .rst_ni    (RST),
        .en_i      (state_q != ST_IDLE),
        .clr_i     (accept),
        .bit_en_i  (state_q == ST_DATA),
        .ps_i      (ps_q),
        .bit_idx_o (bit_idx),
        .wrap_o    (wrap)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= ST_IDLE;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            ps_q      <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else if (accept) begin
            data_q    <= P_DATA;
            par_en_q  <= Parity_Enable;
            par_bit_q <= par_bit_d;
            ps_q      <= eff_prescale(Prescale);
            state_q   <= ST_START;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                end
                ST_START: begin
                    if (wrap) begin
                        state_q <= ST_DATA;
                        tx_q    <= data_q[0];
                    end
                end
                ST_DATA: begin
                    if (wrap) begin
                        if (bit_idx == LAST_BIT) begin
                            state_q <= par_en_q ? ST_PARITY : ST_STOP;
                            tx_q    <= par_en_q ? par_bit_q : 1'b1;
                        end else begin
                            tx_q <= data_q[next_idx];
                        end
                    end
                end
                ST_PARITY: begin
                    if (wrap) begin
                        state_q <= ST_STOP;
                        tx_q    <= 1'b1;
                    end
                end
                ST_STOP: begin
                    if (wrap) begin
                        state_q <= ST_IDLE;
                        tx_q    <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign TX_OUT = tx_q;
    assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// Scoreboard bench for uart_tx_core: expected frames are queued at request time
// and a line monitor checks every cycle of each transmitted frame.
module tb_uart_tx_core;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       Parity_Enable;
    logic       Parity_Type;
    logic [5:0] Prescale;
    logic       TX_OUT;
    logic       Busy;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       pt;
        int         ps;
    } frame_t;

    frame_t exp_q[$];
    int     vectors     = 0;
    int     miscompares = 0;
    bit     mon_en      = 1'b0;
    bit     mon_busy    = 1'b0;

    uart_tx_core dut (
        .CLK           (CLK),
        .RST           (RST),
        .P_DATA        (P_DATA),
        .Data_Valid    (Data_Valid),
        .Parity_Enable (Parity_Enable),
        .Parity_Type   (Parity_Type),
        .Prescale      (Prescale),
        .TX_OUT        (TX_OUT),
        .Busy          (Busy)
    );

    always #5 CLK = ~CLK;

    // Line monitor: a low line while enabled is the first cycle of a start bit.
    task automatic check_frame();
        frame_t     f;
        logic [11:0] bv;
        int         nb;
        int         ps;
        bit         bad;
        logic       exp_b;
        mon_busy = 1'b1;
        vectors++;
        if (exp_q.size() == 0) begin
            $display("FAIL unexpected_frame: start bit seen, busy=%b, required no frame", Busy);
            miscompares++;
            for (int i = 0; i < 3000 && TX_OUT !== 1'b1; i++) @(negedge CLK);
            mon_busy = 1'b0;
            return;
        end
        f  = exp_q.pop_front();
        ps = (f.ps < 4) ? 4 : f.ps;
        bv = '1;
        bv[0] = 1'b0;
        for (int i = 0; i < 8; i++) bv[i+1] = f.d[i];
        if (f.pe) begin
            bv[9] = (^f.d) ^ f.pt;
            nb = 11;
        end else begin
            nb = 10;
        end
        bad = 1'b0;
        for (int k = 0; k < nb * ps; k++) begin
            if (k > 0) @(negedge CLK);
            exp_b = bv[k / ps];
            if (!bad && (TX_OUT !== exp_b || Busy !== 1'b1)) begin
                $display("FAIL frame_%02h cycle %0d: tx_out=%b busy=%b, required tx_out=%b busy=1",
                         f.d, k, TX_OUT, Busy, exp_b);
                miscompares++;
                bad = 1'b1;
            end
        end
        mon_busy = 1'b0;
    endtask

    initial begin
        forever begin
            @(negedge CLK);
            if (mon_en && RST === 1'b1 && TX_OUT === 1'b0) check_frame();
        end
    end

    task automatic send(input logic [7:0] d, input logic pe, input logic pt,
                        input int ps, input bit push);
        frame_t f;
        @(posedge CLK);
        #1;
        P_DATA        = d;
        Parity_Enable = pe;
        Parity_Type   = pt;
        Prescale      = ps[5:0];
        Data_Valid    = 1'b1;
        if (push) begin
            f.d = d; f.pe = pe; f.pt = pt; f.ps = ps;
            exp_q.push_back(f);
        end
        @(posedge CLK);
        #1 Data_Valid = 1'b0;
    endtask

    task automatic busy_len(output int n);
        n = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            if (Busy === 1'b1) n++;
            else break;
        end
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 5000; i++) begin
            @(negedge CLK);
            if (!mon_busy && exp_q.size() == 0 && Busy === 1'b0) return;
        end
        vectors++;
        miscompares++;
        $display("FAIL %s_idle_timeout: busy=%b queued=%0d, required idle", tag, Busy, exp_q.size());
    endtask

    task automatic test_reset();
        RST = 1'b0; Data_Valid = 1'b0; P_DATA = '0;
        Parity_Enable = 1'b0; Parity_Type = 1'b0; Prescale = 6'd8;
        repeat (3) @(negedge CLK);
        vectors++; if (TX_OUT !== 1'b1) begin miscompares++; $display("FAIL reset_tx: got %b, required 1", TX_OUT); end
        vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b, required 0", Busy); end
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        vectors++; if (TX_OUT !== 1'b1) begin miscompares++; $display("FAIL idle_tx: got %b, required 1", TX_OUT); end
        vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy: got %b, required 0", Busy); end
        mon_en = 1'b1;
    endtask

    task automatic test_basic();
        int n;
        send(8'hA5, 1'b0, 1'b0, 8, 1'b1);
        busy_len(n);
        vectors++; if (n !== 80) begin miscompares++; $display("FAIL basic_busy_len: got %0d, required 80", n); end
        wait_idle("basic");
    endtask

    task automatic test_parity();
        int n;
        send(8'h0F, 1'b1, 1'b0, 16, 1'b1);
        busy_len(n);
        vectors++; if (n !== 176) begin miscompares++; $display("FAIL even_busy_len: got %0d, required 176", n); end
        wait_idle("even");
        send(8'h0F, 1'b1, 1'b1, 16, 1'b1);
        wait_idle("odd");
        send(8'hFF, 1'b1, 1'b0, 8, 1'b1);
        busy_len(n);
        vectors++; if (n !== 88) begin miscompares++; $display("FAIL ff_even_busy_len: got %0d, required 88", n); end
        wait_idle("ff_even");
    endtask

    task automatic test_back_to_back();
        int     n;
        frame_t f;
        @(posedge CLK);
        #1;
        P_DATA = 8'h55; Parity_Enable = 1'b0; Parity_Type = 1'b0; Prescale = 6'd8; Data_Valid = 1'b1;
        f.d = 8'h55; f.pe = 1'b0; f.pt = 1'b0; f.ps = 8;
        exp_q.push_back(f);
        @(posedge CLK);
        #1 P_DATA = 8'hAA;
        f.d = 8'hAA;
        exp_q.push_back(f);
        fork
            busy_len(n);
            begin
                repeat (80) @(posedge CLK);
                #1 Data_Valid = 1'b0;
            end
        join
        vectors++; if (n !== 160) begin miscompares++; $display("FAIL b2b_busy_len: got %0d, required 160", n); end
        wait_idle("b2b");
    endtask

    task automatic test_ignore();
        int n;
        send(8'h3A, 1'b0, 1'b0, 8, 1'b1);
        fork
            busy_len(n);
            begin
                repeat (20) @(posedge CLK);
                #1; P_DATA = 8'hFF; Data_Valid = 1'b1;
                @(posedge CLK);
                #1 Data_Valid = 1'b0;
            end
        join
        vectors++; if (n !== 80) begin miscompares++; $display("FAIL ignore_busy_len: got %0d, required 80", n); end
        wait_idle("ignore");
    endtask

    task automatic test_config_change();
        int     n;
        frame_t f;
        send(8'hC3, 1'b0, 1'b0, 8, 1'b1);
        fork
            busy_len(n);
            begin
                repeat (30) @(posedge CLK);
                #1; P_DATA = 8'h00; Prescale = 6'd16; Parity_Enable = 1'b1; Parity_Type = 1'b1;
            end
        join
        vectors++; if (n !== 80) begin miscompares++; $display("FAIL cfg_old_busy_len: got %0d, required 80", n); end
        wait_idle("cfg_old");
        @(posedge CLK);
        #1 Data_Valid = 1'b1;
        f.d = 8'h00; f.pe = 1'b1; f.pt = 1'b1; f.ps = 16;
        exp_q.push_back(f);
        @(posedge CLK);
        #1 Data_Valid = 1'b0;
        busy_len(n);
        vectors++; if (n !== 176) begin miscompares++; $display("FAIL cfg_new_busy_len: got %0d, required 176", n); end
        wait_idle("cfg_new");
    endtask

    task automatic test_reset_mid_frame();
        int n;
        mon_en = 1'b0;
        send(8'h96, 1'b0, 1'b0, 8, 1'b0);
        repeat (35) @(posedge CLK);
        #2;
        vectors++; if (TX_OUT !== 1'b0) begin miscompares++; $display("FAIL bit3_tx: got %b, required 0", TX_OUT); end
        vectors++; if (Busy !== 1'b1) begin miscompares++; $display("FAIL bit3_busy: got %b, required 1", Busy); end
        RST = 1'b0;
        #1;
        vectors++; if (TX_OUT !== 1'b1) begin miscompares++; $display("FAIL async_rst_tx: got %b, required 1", TX_OUT); end
        vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL async_rst_busy: got %b, required 0", Busy); end
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        vectors++; if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
            miscompares++; $display("FAIL post_rst_idle: tx=%b busy=%b, required tx=1 busy=0", TX_OUT, Busy);
        end
        mon_en = 1'b1;
        send(8'h3C, 1'b1, 1'b0, 2, 1'b1);
        busy_len(n);
        vectors++; if (n !== 44) begin miscompares++; $display("FAIL min_ps_busy_len: got %0d, required 44", n); end
        wait_idle("min_ps");
    endtask

    task automatic test_random();
        int         n;
        int         ps;
        logic [7:0] d;
        logic       pe;
        logic       pt;
        for (int i = 0; i < 6; i++) begin
            case ($urandom_range(0, 2))
                0:       ps = 8;
                1:       ps = 16;
                default: ps = 32;
            endcase
            d  = 8'($urandom);
            pe = 1'($urandom);
            pt = 1'($urandom);
            send(d, pe, pt, ps, 1'b1);
            busy_len(n);
            vectors++; if (n !== (10 + int'(pe)) * ps) begin
                miscompares++; $display("FAIL rand%0d_busy_len: got %0d, required %0d", i, n, (10 + int'(pe)) * ps);
            end
            wait_idle("rand");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_back_to_back();
        test_ignore();
        test_config_change();
        test_reset_mid_frame();
        test_random();
        repeat (5) @(negedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: bench still running, required completion");
        $fatal(1, "timeout");
    end

endmodule
